fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction fetch/issue front end of the 60-bit processor; sits on the opposite end of the control interface from the opcode decoder.
- Owns the PC, fetches 60-bit words from instruction memory, and issues the 4-bit opcode plus the full word downstream.
- Consumes the decoder's registered branch_en/jump_en one cycle after issue to choose the next PC.
- Multi-cycle, non-pipelined: one instruction in flight at a time.

Parameters:
ADDR_W, 8, instruction memory word-address width; PC wraps modulo 2^ADDR_W
INSTR_W, 60, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYC, 16, fetch wait limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  one-cycle fetch request pulse
imem_addr  output  ADDR_W  fetch address; stable from FETCH until the response is accepted
imem_valid  input  1  instruction memory response valid
imem_data  input  INSTR_W  instruction memory response data
stall  input  1  downstream hold
opcode  output  4  opcode to the decoder
instr  output  INSTR_W  registered full instruction word
instr_valid  output  1  one-cycle issue strobe
branch_en  input  1  from the decoder, valid in RESOLVE
jump_en  input  1  from the decoder, valid in RESOLVE
cond_true  input  1  branch condition from the ALU, sampled in RESOLVE
target  input  ADDR_W  jump/branch absolute target, sampled in RESOLVE
pc  output  ADDR_W  address of the current instruction
fetch_err  output  1  timeout pulse (macro only; otherwise tied 0)

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; pc = imem_addr = RESET_PC.
  - imem_req, instr_valid and fetch_err = 0; opcode = 0; instr = 0.
  - Reset overrides every other input and takes effect in any state, including mid-WAIT.
- States: IDLE, FETCH, WAIT, ISSUE, RESOLVE.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH:
  - imem_req = 1 for exactly this cycle; imem_addr = pc.
  - If stall = 1, stay in FETCH with imem_req = 0.
  - Otherwise go to WAIT.
- WAIT:
  - Hold imem_addr.
  - On imem_valid = 1: latch imem_data into instr, drive opcode = imem_data[INSTR_W-1:INSTR_W-4], go to ISSUE.
  - stall is ignored in WAIT.
- ISSUE:
  - instr_valid = 1 for exactly one cycle; opcode and instr are held.
  - Then go to RESOLVE.
  - The decoder registers its flags on this edge, so they are valid in RESOLVE.
- RESOLVE:
  - Sample branch_en, jump_en, cond_true and target.
  - Next pc priority: jump_en -> target; else branch_en & cond_true -> target; else pc + 1, truncated to ADDR_W bits (0xFF -> 0x00 for ADDR_W = 8).
  - If stall = 1, hold in RESOLVE and re-sample each cycle; pc updates only on the exit cycle.
  - Exit goes to FETCH.
- branch_en and jump_en both high: jump wins.
- imem_valid outside WAIT is ignored; this includes a stale response arriving after reset.
- opcode and instr hold their last issued value until the next WAIT acceptance.
- Latency: with a 1-cycle memory and no stall, one instruction every 4 cycles (FETCH, WAIT, ISSUE, RESOLVE).
- The first imem_req occurs 2 cycles after rst deasserts.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on WAIT entry and increments each cycle in WAIT without imem_valid.
  - When it reaches TIMEOUT_CYC: fetch_err = 1 for one cycle, the state returns to FETCH, and the same pc is re-requested.
  - imem_valid arriving on the timeout cycle is accepted; in that case there is no error.
- Without the macro: fetch_err is constant 0 and WAIT has no time limit.

Test Plan:
- Sequential fetch: rst 2 cycles, memory returns opcode 0 words with 1-cycle latency, decoder flags 0 -> imem_addr 0,1,2; instr_valid pulses spaced 4 cycles; opcode 0.
- Jump: word at pc 0x03 has opcode 5, jump_en = 1, target = 0x40 in RESOLVE -> next imem_addr 0x40, pc 0x40.
- Branch: pc 0x10, opcode 12, branch_en = 1, target = 0x20; cond_true = 0 -> next pc 0x11; repeat with cond_true = 1 -> next pc 0x20; both flags high with target 0x30 -> 0x30.
- Wrap and stall: pc 0xFF, no flags -> next pc 0x00; stall held 3 cycles in RESOLVE -> pc unchanged until stall drops, then FETCH.
- Reset mid-WAIT: rst during WAIT at pc 0x22, then imem_valid one cycle after -> pc 0x00, instr_valid stays 0, stale data not issued, fresh fetch from 0x00.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYC = 16): imem_valid held 0 -> fetch_err pulse after 16 WAIT cycles, imem_req re-issued to the same address; without the macro no pulse, and the FSM stays in WAIT.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/issue front end of the 60-bit processor.
// Owns the PC, fetches one word at a time from instruction memory, issues the
// opcode plus the full word to the decoder, then picks the next PC from the
// decoder's branch/jump flags one cycle after issue. One instruction in flight.
//
// Optional build macro FETCH_TIMEOUT_EN: bounds the WAIT state to TIMEOUT_CYC
// cycles; on expiry fetch_err pulses and the same PC is requested again.
// Without the macro fetch_err is tied low and WAIT waits indefinitely.
module fetch_sequencer #(
    parameter int                 ADDR_W      = 8,
    parameter int                 INSTR_W     = 60,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int                 TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               branch_en,
    input  logic               jump_en,
    input  logic               cond_true,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_err
);

    // The wait counter compares against TIMEOUT_CYC-1, so zero is meaningless.
    if (TIMEOUT_CYC < 1) begin : g_timeout_range
        $error("fetch_sequencer: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_RESOLVE
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc_q, pc_nx;
    logic [INSTR_W-1:0]  instr_q;
    logic                tmo;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: zero outside WAIT (so it is clear on entry), counts idle WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT)
            wait_cnt <= '0;
        else if (!imem_valid)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Timeout fires on the TIMEOUT_CYC-th WAIT cycle; a response on that cycle wins.
    assign tmo = (state == S_WAIT) && !imem_valid &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    // Next-state, next-PC and strobe outputs; strobes are pure functions of state.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                // A stalled request is simply not issued; the address stays put.
                if (!stall) begin
                    imem_req = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    state_nx = S_ISSUE;
                end else if (tmo) begin
                    fetch_err = 1'b1;
                    state_nx  = S_FETCH;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                state_nx    = S_RESOLVE;
            end
            S_RESOLVE: begin
                // Flags are re-sampled every stalled cycle; PC moves only on exit.
                if (!stall) begin
                    state_nx = S_FETCH;
                    if (jump_en)
                        pc_nx = target;
                    else if (branch_en && cond_true)
                        pc_nx = target;
                    else
                        pc_nx = pc_q + ADDR_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, PC and issued-word registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            // Responses are only accepted in WAIT; stale ones elsewhere are dropped.
            if (state == S_WAIT && imem_valid)
                instr_q <= imem_data;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[INSTR_W-1 -: 4];

endmodule
